// File: rtl/didactic_apb_requester.sv
// Single-outstanding APB requester: request/response handshake in, APB transfer out.
// Optional ACCESS-phase timeout is built when APB_REQ_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request, no APB activity
// SETUP  | psel high, penable low, address phase
// ACCESS | psel and penable high, waiting for pready (or timeout)
// RESP   | response held on rsp_* until rsp_ready_i
module didactic_apb_requester #(
  parameter int unsigned ApbAddrWidth  = 32'd12,
  parameter int unsigned ApbDataWidth  = 32'd32,
  parameter int unsigned TimeoutCycles = 16'd255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ApbAddrWidth-1:0] req_addr_i,
  input  logic [ApbDataWidth-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ApbDataWidth-1:0] rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ApbAddrWidth-1:0] paddr_o,
  output logic [ApbDataWidth-1:0] pwdata_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [ApbDataWidth-1:0] prdata_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q;
  logic [ApbAddrWidth-1:0] addr_q;
  logic [ApbDataWidth-1:0] wdata_q;
  logic [ApbDataWidth-1:0] rdata_q;
  logic                    err_q;
  logic                    timeout;

  if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
    $error("TimeoutCycles must be in 1..65535");
  end

`ifdef APB_REQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLoad = 16'(TimeoutCycles - 1);

  logic [15:0] cnt_q;

  // Down-counter loaded in SETUP; terminal count marks the last allowed ACCESS cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= TimeoutLoad;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign timeout = (state_q == ACCESS) && !pready_i && (cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (state_q == ACCESS) begin
        // pready wins over a timeout landing in the same cycle
        if (pready_i) begin
          rdata_q <= write_q ? '0 : prdata_i;
          err_q   <= pslverr_i;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);
  assign pwrite_o    = write_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_didactic_apb_requester.sv
// Self-checking bench for didactic_apb_requester: directed and randomized transfers
// checked cycle-by-cycle against the expected transaction timeline.
module tb_didactic_apb_requester;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int checks = 0;
  int failures = 0;

  didactic_apb_requester #(
    .ApbAddrWidth (12),
    .ApbDataWidth (32),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .pready_i   (pready),
    .pslverr_i  (pslverr),
    .prdata_i   (prdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. wait_n = ACCESS cycles with pready low before completion.
  task automatic do_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input int wait_n, input logic [31:0] rd, input bit slv,
                        input int rsp_dly, input string tag);
    bit          timed_out;
    int          n_acc;
    logic [31:0] exp_rdata;
    bit          exp_err;
    timed_out = TO_EN && (wait_n >= TO);
    n_acc     = timed_out ? TO : wait_n + 1;
    exp_rdata = (timed_out || wr) ? 32'h0 : rd;
    exp_err   = timed_out ? 1'b1 : slv;

    // cycle 0: handshake
    checks++;
    if ({req_ready, rsp_valid, psel} !== 3'b100) begin
      failures++;
      $display("FAIL %s idle_state got ready/rspv/psel=%b exp=100", tag, {req_ready, rsp_valid, psel});
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    next_cycle();

    // cycle 1: SETUP; garbage on request and completer inputs must be ignored
    req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    checks++;
    if ({psel, penable, req_ready} !== 3'b100) begin
      failures++;
      $display("FAIL %s setup_ctrl got psel/pen/ready=%b exp=100", tag, {psel, penable, req_ready});
    end
    checks++;
    if ({pwrite, paddr, pwdata} !== {wr, addr, wd}) begin
      failures++;
      $display("FAIL %s setup_bus got w=%b a=%h d=%h exp w=%b a=%h d=%h", tag, pwrite, paddr, pwdata, wr, addr, wd);
    end

    for (int k = 0; k < n_acc; k++) begin
      next_cycle();
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        failures++;
        $display("FAIL %s access%0d_ctrl got psel/pen/rspv=%b exp=110", tag, k, {psel, penable, rsp_valid});
      end
      checks++;
      if ({pwrite, paddr, pwdata} !== {wr, addr, wd}) begin
        failures++;
        $display("FAIL %s access%0d_bus got w=%b a=%h d=%h exp w=%b a=%h d=%h", tag, k, pwrite, paddr, pwdata, wr, addr, wd);
      end
      pready  = !timed_out && (k == n_acc - 1);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? slv : 1'b0;
    end

    next_cycle();
    for (int d = 0; d <= rsp_dly; d++) begin
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      checks++;
      if ({rsp_valid, psel, penable, req_ready} !== 4'b1000) begin
        failures++;
        $display("FAIL %s resp%0d_ctrl got rspv/psel/pen/ready=%b exp=1000", tag, d, {rsp_valid, psel, penable, req_ready});
      end
      checks++;
      if ({rsp_err, rsp_rdata} !== {exp_err, exp_rdata}) begin
        failures++;
        $display("FAIL %s resp%0d_data got err=%b rdata=%h exp err=%b rdata=%h", tag, d, rsp_err, rsp_rdata, exp_err, exp_rdata);
      end
      rsp_ready = (d == rsp_dly);
      next_cycle();
    end
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s back_to_idle got ready/rspv=%b exp=10", tag, {req_ready, rsp_valid});
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got psel=%b pen=%b rspv=%b paddr=%h rdata=%h err=%b exp all 0",
               psel, penable, rsp_valid, paddr, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    next_cycle();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_directed();
    do_txn(1'b1, 12'h014, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 0, "write_min_latency");
    do_txn(1'b0, 12'h020, 32'h0, 3, 32'h12345678, 1'b0, 0, "read_wait3");
    do_txn(1'b0, 12'h030, 32'h0, 1, 32'hA5A5A5A5, 1'b1, 5, "read_slverr_stall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn(1'(i), 12'(16 * i), 32'(i) * 32'h01010101, 0, 32'h1000 + 32'(i), 1'b0, 0, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_txn(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 6)), $urandom,
             1'($urandom), int'($urandom_range(0, 3)), "rand");
  endtask

  task automatic test_timeout();
`ifdef APB_REQ_TIMEOUT_EN
    do_txn(1'b0, 12'h044, 32'h0, 10, 32'h55AA55AA, 1'b0, 1, "timeout_expire");
    do_txn(1'b0, 12'h048, 32'h0, TO - 1, 32'h600DF00D, 1'b0, 0, "timeout_ready_last");
    do_txn(1'b1, 12'h04C, 32'h11112222, TO, 32'h0, 1'b0, 0, "timeout_write");
`endif
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h0F0; req_wdata = 32'h0;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, pwrite, paddr, pwdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_access got psel=%b pen=%b rspv=%b paddr=%h exp all 0", psel, penable, rsp_valid, paddr);
    end
    pready = 1'b1; prdata = 32'hBAD0BAD0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    pready = 1'b0;
    next_cycle();
    checks++;
    if ({req_ready, rsp_valid, psel} !== 3'b100) begin
      failures++;
      $display("FAIL rst_release got ready/rspv/psel=%b exp=100", {req_ready, rsp_valid, psel});
    end
    do_txn(1'b0, 12'h0F4, 32'h0, 2, 32'h0BADCAFE, 1'b0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
